// File: rtl/instr_reg_scheduler_if.sv
// Requester, instruction-register and consumer signals of the instruction register scheduler.
// The slave modport is the scheduler side; master is the requester/register/consumer side.
interface instr_reg_scheduler_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 32,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned IW_W   = 3 * OP_W + OPC_W + OP_W
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*OPC_W-1:0] req_opcode;
    logic [2*OP_W-1:0]  req_op_a;
    logic [2*OP_W-1:0]  req_op_b;
    logic               load_en;
    logic [OPC_W-1:0]   opcode;
    logic [OP_W-1:0]    operand_a;
    logic [OP_W-1:0]    operand_b;
    logic [ADDR_W-1:0]  write_pointer;
    logic [ADDR_W-1:0]  read_pointer;
    logic [IW_W-1:0]    instruction_word;
    logic               rd_valid;
    logic               rd_ready;
    logic [IW_W-1:0]    rd_data;
    logic               rd_src;

    modport slave (
        input  req_valid, req_opcode, req_op_a, req_op_b, instruction_word, rd_ready,
        output req_ready, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output rd_valid, rd_data, rd_src
    );

    modport master (
        output req_valid, req_opcode, req_op_a, req_op_b, instruction_word, rd_ready,
        input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  rd_valid, rd_data, rd_src
    );
endinterface

// File: rtl/instr_reg_scheduler.sv
// Owns the instruction register ports: round-robin arbitration of two requesters, write/read
// pointer sequencing, occupancy tracking and per-requester grant counters.
module instr_reg_scheduler #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 32,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned IW_W   = 3 * OP_W + OPC_W + OP_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 flush,
    instr_reg_scheduler_if.slave bus,
    output logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q;
    logic               busy_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [ADDR_W:0]    count_q;
    logic [ADDR_W:0]    count_d;
    logic               prio_q;
    logic [DEPTH-1:0]   src_tag_q;
    logic [CNT_W-1:0]   gcnt0_q;
    logic [CNT_W-1:0]   gcnt1_q;

    logic               rd_fire;
    logic               full;
    logic               can_gnt;
    logic               gnt_idx;
    logic               accept;
    logic               sel;
    logic [IW_W-1:0]    rd_word;

    // A full register still grants when a read frees a slot in the same cycle.
    always_comb begin
        rd_fire = (count_q != '0) && bus.rd_ready;
        full    = (count_q == FULL_CNT);
        can_gnt = (state_q == StRun) && !flush && (!full || rd_fire);
        gnt_idx = (&bus.req_valid) ? prio_q : bus.req_valid[1];
        accept  = can_gnt && (|bus.req_valid);
        sel     = accept ? gnt_idx : 1'b0;
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !rd_fire) begin
            count_d = count_q + 1'b1;
        end else if (!accept && rd_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    assign bus.load_en       = accept;
    assign bus.opcode        = sel ? bus.req_opcode[OPC_W +: OPC_W] : bus.req_opcode[0 +: OPC_W];
    assign bus.operand_a     = sel ? bus.req_op_a[OP_W +: OP_W] : bus.req_op_a[0 +: OP_W];
    assign bus.operand_b     = sel ? bus.req_op_b[OP_W +: OP_W] : bus.req_op_b[0 +: OP_W];
    assign bus.write_pointer = wr_ptr_q;
    assign bus.read_pointer  = rd_ptr_q;
    assign bus.rd_valid      = (count_q != '0);
    assign rd_word           = bus.instruction_word;
    assign bus.rd_data       = rd_word;
    assign bus.rd_src        = src_tag_q[rd_ptr_q];

    assign count      = count_q;
    assign busy       = busy_q;
    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (flush || (!enable && count_q == '0)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (enable) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Flush clears pointers and occupancy only; prio and source tags survive it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prio_q    <= 1'b0;
            src_tag_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q            <= wr_ptr_q + 1'b1;
                src_tag_q[wr_ptr_q] <= sel;
                prio_q              <= ~sel;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (accept) begin
            if (!sel && gcnt0_q != '1) begin
                gcnt0_q <= gcnt0_q + 1'b1;
            end
            if (sel && gcnt1_q != '1) begin
                gcnt1_q <= gcnt1_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler with a behavioural instruction register attached.
module tb_instr_reg_scheduler;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OP_W    = 32;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IW_W    = 3 * OP_W + OPC_W + OP_W;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OPA_LSB = IW_W - OPC_W - OP_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             flush;
    logic [ADDR_W:0]  count;
    logic             busy;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
    logic [IW_W-1:0]  mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    instr_reg_scheduler_if #(
        .ADDR_W(ADDR_W), .OP_W(OP_W), .OPC_W(OPC_W), .IW_W(IW_W)
    ) bus ();

    instr_reg_scheduler #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .OPC_W(OPC_W), .IW_W(IW_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .flush      (flush),
        .bus        (bus),
        .count      (count),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    assign bus.instruction_word = mem[bus.read_pointer];

    always @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b, {(2*OP_W){1'b0}}};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic [OPC_W-1:0] opc, input logic [OP_W-1:0] a,
                           input logic [OP_W-1:0] b);
        bus.req_opcode[idx*OPC_W +: OPC_W] = opc;
        bus.req_op_a[idx*OP_W +: OP_W]     = a;
        bus.req_op_b[idx*OP_W +: OP_W]     = b;
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_opcode = '0;
        bus.req_op_a   = '0;
        bus.req_op_b   = '0;
        bus.rd_ready   = 1'b0;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_load_en", 64'(bus.load_en), 64'd0);
        check("rst_wp", 64'(bus.write_pointer), 64'd0);
        check("rst_rp", 64'(bus.read_pointer), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_gcnt0", 64'(grant_cnt0), 64'd0);
        check("rst_gcnt1", 64'(grant_cnt1), 64'd0);
        check("rst_rd_src", 64'(bus.rd_src), 64'd0);
        #1;
        reset_n = 1'b1;

        // Single ADD from requester 0
        enable        = 1'b1;
        set_req(0, 4'h1, 32'd5, 32'd3);
        bus.req_valid = 2'b01;
        settle();
        check("idle_no_grant", 64'(bus.req_ready), 64'd0);
        tick();
        settle();
        check("t1_load_en", 64'(bus.load_en), 64'd1);
        check("t1_wp", 64'(bus.write_pointer), 64'd0);
        check("t1_req_ready", 64'(bus.req_ready), 64'b01);
        check("t1_opcode", 64'(bus.opcode), 64'h1);
        check("t1_op_a", 64'(bus.operand_a), 64'd5);
        check("t1_op_b", 64'(bus.operand_b), 64'd3);
        tick();
        bus.req_valid = 2'b00;
        settle();
        check("t1_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("t1_rd_src", 64'(bus.rd_src), 64'd0);
        check("t1_count", 64'(count), 64'd1);
        check("t1_rd_opa", 64'(bus.rd_data[OPA_LSB +: OP_W]), 64'd5);
        check("t1_gcnt0", 64'(grant_cnt0), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);

        // Round-robin with both requesters valid
        do_reset();
        tick();
        set_req(0, 4'h2, 32'd10, 32'd0);
        set_req(1, 4'h3, 32'd20, 32'd0);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_ready", 64'(bus.req_ready), (i % 2 == 1) ? 64'b10 : 64'b01);
            check("rr_wp", 64'(bus.write_pointer), 64'(i));
            tick();
        end
        bus.req_valid = 2'b00;
        settle();
        check("rr_gcnt0", 64'(grant_cnt0), 64'd2);
        check("rr_gcnt1", 64'(grant_cnt1), 64'd2);
        check("rr_count", 64'(count), 64'd4);
        check("rr_rd_src", 64'(bus.rd_src), 64'd0);
        check("rr_rd_opa", 64'(bus.rd_data[OPA_LSB +: OP_W]), 64'd10);

        // Fill to full, then simultaneous write and read at wrap
        bus.req_valid = 2'b01;
        repeat (28) tick();
        settle();
        check("full_count", 64'(count), 64'd32);
        check("full_ready", 64'(bus.req_ready), 64'd0);
        check("full_load_en", 64'(bus.load_en), 64'd0);
        check("full_wp", 64'(bus.write_pointer), 64'd0);
        bus.rd_ready = 1'b1;
        settle();
        check("fullrw_ready", 64'(bus.req_ready), 64'b01);
        check("fullrw_load_en", 64'(bus.load_en), 64'd1);
        check("fullrw_rp", 64'(bus.read_pointer), 64'd0);
        tick();
        bus.req_valid = 2'b00;
        bus.rd_ready  = 1'b0;
        settle();
        check("fullrw_count", 64'(count), 64'd32);
        check("fullrw_wp", 64'(bus.write_pointer), 64'd1);
        check("fullrw_rp", 64'(bus.read_pointer), 64'd1);
        check("fullrw_gcnt0", 64'(grant_cnt0), 64'd31);
        check("fullrw_rd_src", 64'(bus.rd_src), 64'd1);
        check("fullrw_rd_opa", 64'(bus.rd_data[OPA_LSB +: OP_W]), 64'd20);

        // Drain after enable drops
        do_reset();
        tick();
        bus.req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 4'h5, 32'(100 + k), 32'd0);
            tick();
        end
        bus.req_valid = 2'b00;
        enable        = 1'b0;
        tick();
        settle();
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_count", 64'(count), 64'd3);
        bus.req_valid = 2'b01;
        settle();
        check("drain_no_grant", 64'(bus.req_ready), 64'd0);
        check("drain_no_load", 64'(bus.load_en), 64'd0);
        bus.req_valid = 2'b00;
        bus.rd_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("drain_rd_valid", 64'(bus.rd_valid), 64'd1);
            check("drain_rd_opa", 64'(bus.rd_data[OPA_LSB +: OP_W]), 64'(100 + k));
            tick();
        end
        bus.rd_ready = 1'b0;
        settle();
        check("drain_empty_count", 64'(count), 64'd0);
        check("drain_empty_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("drain_busy_hold", 64'(busy), 64'd1);
        tick();
        settle();
        check("drain_busy_fall", 64'(busy), 64'd0);

        // Flush with count=5 alongside write and read requests
        do_reset();
        enable = 1'b1;
        tick();
        set_req(0, 4'h7, 32'd7, 32'd0);
        bus.req_valid = 2'b01;
        repeat (5) tick();
        bus.req_valid = 2'b00;
        settle();
        check("fl_pre_count", 64'(count), 64'd5);
        flush         = 1'b1;
        bus.req_valid = 2'b11;
        bus.rd_ready  = 1'b1;
        settle();
        check("fl_load_en", 64'(bus.load_en), 64'd0);
        check("fl_ready", 64'(bus.req_ready), 64'd0);
        tick();
        flush        = 1'b0;
        bus.rd_ready = 1'b0;
        settle();
        check("fl_count", 64'(count), 64'd0);
        check("fl_wp", 64'(bus.write_pointer), 64'd0);
        check("fl_rp", 64'(bus.read_pointer), 64'd0);
        check("fl_busy", 64'(busy), 64'd1);
        check("fl_gcnt0", 64'(grant_cnt0), 64'd5);
        check("fl_prio_kept", 64'(bus.req_ready), 64'b10);
        bus.req_valid = 2'b00;

        // Asynchronous reset mid-burst
        do_reset();
        tick();
        bus.req_valid = 2'b01;
        repeat (7) tick();
        settle();
        check("ar_pre_count", 64'(count), 64'd7);
        reset_n = 1'b0;
        #1;
        check("ar_count", 64'(count), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_ready", 64'(bus.req_ready), 64'd0);
        check("ar_load_en", 64'(bus.load_en), 64'd0);
        check("ar_wp", 64'(bus.write_pointer), 64'd0);
        check("ar_rp", 64'(bus.read_pointer), 64'd0);
        check("ar_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("ar_gcnt0", 64'(grant_cnt0), 64'd0);
        check("ar_rd_src", 64'(bus.rd_src), 64'd0);
        bus.req_valid = 2'b00;
        reset_n       = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
